// File: rtl/cpu_pkg.sv
// Shared CPU definitions for operand forwarding: widths, operand-mux select codes,
// and the in-flight destination tracker entry.
package cpu_pkg;

  localparam int SEL_W = 3;
  localparam int RA_W  = 5;

  localparam logic [SEL_W-1:0] OPSEL_RF      = 3'd0;
  localparam logic [SEL_W-1:0] OPSEL_MEM_ALU = 3'd1;
  localparam logic [SEL_W-1:0] OPSEL_WB_ALU  = 3'd2;
  localparam logic [SEL_W-1:0] OPSEL_WB_LOAD = 3'd3;

  typedef struct packed {
    logic            v;
    logic            wreg;
    logic [RA_W-1:0] rd;
    logic            is_load;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '{v: 1'b0, wreg: 1'b0, rd: 5'd0, is_load: 1'b0};

  // Register 0 is hard-wired, so a producer never forwards to it.
  function automatic logic entry_hits(input trk_entry_t e,
                                      input logic [RA_W-1:0] src,
                                      input logic src_used);
    return e.v & e.wreg & (e.rd == src) & (src != 5'd0) & src_used;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source forwarding decision against the EX/MEM/WB tracker entries.
// Bypass paths exist only when OPFWD_BYPASS_EN is defined; otherwise EX/MEM matches stall.
module fwd_match
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0]  src,
  input  logic             src_used,
  input  trk_entry_t       ex_e,
  input  trk_entry_t       mem_e,
  input  trk_entry_t       wb_e,
  output logic [SEL_W-1:0] code,
  output logic             load_haz
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_is_load;

  assign ex_hit  = entry_hits(ex_e,  src, src_used);
  assign mem_hit = entry_hits(mem_e, src, src_used);
  assign wb_hit  = entry_hits(wb_e,  src, src_used);
  assign unused_is_load = ^{ex_e.is_load, mem_e.is_load, wb_e.is_load};

  // Youngest producer wins; a WB producer is covered by regfile write-through.
  always_comb begin
    code     = OPSEL_RF;
    load_haz = 1'b0;
`ifdef OPFWD_BYPASS_EN
    if (ex_hit) begin
      if (ex_e.is_load) begin
        load_haz = 1'b1;
      end else begin
        code = OPSEL_MEM_ALU;
      end
    end else if (mem_hit) begin
      if (mem_e.is_load) begin
        code = OPSEL_WB_LOAD;
      end else begin
        code = OPSEL_WB_ALU;
      end
    end else if (wb_hit) begin
      code = OPSEL_RF;
    end else begin
      code = OPSEL_RF;
    end
`else
    if (ex_hit || mem_hit) begin
      load_haz = 1'b1;
    end else if (wb_hit) begin
      code = OPSEL_RF;
    end else begin
      code = OPSEL_RF;
    end
`endif
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding controller: tracks EX/MEM/WB destinations and registers the EX operand
// mux selects. OPFWD_BYPASS_EN enables the bypass paths; undefined, every EX/MEM dependency stalls.
module operand_fwd_ctrl
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wreg,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_is_load,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b
);

  trk_entry_t       ex_q,    ex_d;
  trk_entry_t       mem_q,   mem_d;
  trk_entry_t       wb_q,    wb_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;

  trk_entry_t       id_e;
  logic [SEL_W-1:0] code_a;
  logic [SEL_W-1:0] code_b;
  logic             haz_a;
  logic             haz_b;
  logic             stall_req;

  fwd_match u_match_rs (
    .src      (id_rs),
    .src_used (id_rs_used),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .wb_e     (wb_q),
    .code     (code_a),
    .load_haz (haz_a)
  );

  fwd_match u_match_rt (
    .src      (id_rt),
    .src_used (id_rt_used),
    .ex_e     (ex_q),
    .mem_e    (mem_q),
    .wb_e     (wb_q),
    .code     (code_b),
    .load_haz (haz_b)
  );

  assign id_e = '{v: id_valid, wreg: id_wreg, rd: id_rd, is_load: id_is_load};

  assign stall_req = (haz_a | haz_b) & id_valid & ~flush & ~hold;
  assign stall     = stall_req;
  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;

  // Next state: hold freezes everything; flush/stall push a bubble while MEM/WB keep draining.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (hold) begin
      ex_d = ex_q;
    end else begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush || stall_req) begin
        ex_d    = TRK_BUBBLE;
        sel_a_d = OPSEL_RF;
        sel_b_d = OPSEL_RF;
      end else if (id_valid) begin
        ex_d    = id_e;
        sel_a_d = code_a;
        sel_b_d = code_b;
      end else begin
        ex_d    = TRK_BUBBLE;
        sel_a_d = OPSEL_RF;
        sel_b_d = OPSEL_RF;
      end
    end
  end

  // Tracker and select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= TRK_BUBBLE;
      mem_q   <= TRK_BUBBLE;
      wb_q    <= TRK_BUBBLE;
      sel_a_q <= OPSEL_RF;
      sel_b_q <= OPSEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl; expectations follow whether OPFWD_BYPASS_EN is defined.
module tb_operand_fwd_ctrl;

`ifdef OPFWD_BYPASS_EN
  localparam int S_EX_ALU  = 0;
  localparam int S_MEM_ALU = 0;
  localparam int S_EX_LD   = 1;
  localparam int S_MEM_LD  = 0;
  localparam logic [2:0] C_EX_ALU  = 3'd1;
  localparam logic [2:0] C_MEM_ALU = 3'd2;
  localparam logic [2:0] C_LOAD    = 3'd3;
  localparam logic       STALL_NOW_EX_ALU = 1'b0;
`else
  localparam int S_EX_ALU  = 2;
  localparam int S_MEM_ALU = 1;
  localparam int S_EX_LD   = 2;
  localparam int S_MEM_LD  = 1;
  localparam logic [2:0] C_EX_ALU  = 3'd0;
  localparam logic [2:0] C_MEM_ALU = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd0;
  localparam logic       STALL_NOW_EX_ALU = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic       id_wreg = 1'b0;
  logic [4:0] id_rd = 5'd0;
  logic       id_is_load = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [2:0] sel_a;
  logic [2:0] sel_b;

  int n_pass  = 0;
  int n_total = 0;
  int st;

  operand_fwd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_wreg    (id_wreg),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .hold       (hold),
    .flush      (flush),
    .stall      (stall),
    .sel_a      (sel_a),
    .sel_b      (sel_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic present(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                         input logic rt_u, input logic wreg, input logic [4:0] rd,
                         input logic ld);
    id_valid = 1'b1; id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
    id_wreg = wreg; id_rd = rd; id_is_load = ld;
  endtask

  task automatic idle_id();
    id_valid = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_wreg = 1'b0; id_is_load = 1'b0;
  endtask

  // Presents an instruction, counts stall cycles until it enters EX, returns #1 after that edge.
  task automatic issue(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                       input logic rt_u, input logic wreg, input logic [4:0] rd,
                       input logic ld, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    present(rs, rs_u, rt, rt_u, wreg, rd, ld);
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    idle_id();
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    idle_id();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    chk("rst_stall", stall, 0);

    // add $3 then sub rs=$3, back to back
    @(posedge clk); #1;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, st);
    issue(5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd6, 1'b0, st);
    chk("ex_alu_stalls", st, S_EX_ALU);
    chk("ex_alu_sel_a", sel_a, C_EX_ALU);
    chk("ex_alu_sel_b", sel_b, 0);
    idle_cycles(4);

    // one-instruction gap
    issue(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, st);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, st);
    issue(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, st);
    chk("mem_alu_stalls", st, S_MEM_ALU);
    chk("mem_alu_sel_a", sel_a, C_MEM_ALU);
    idle_cycles(4);

    // two-instruction gap: regfile write-through
    issue(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, st);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, st);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, st);
    issue(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, st);
    chk("wb_stalls", st, 0);
    chk("wb_sel_a", sel_a, 0);
    idle_cycles(4);

    // lw $5 then add rt=$5
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, st);
    present(5'd8, 1'b1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0);
    #1 chk("lu_stall_now", stall, 1);
    issue(5'd8, 1'b1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, st);
    chk("lu_stalls", st, S_EX_LD);
    chk("lu_sel_b", sel_b, C_LOAD);
    chk("lu_sel_a", sel_a, 0);
    idle_cycles(4);

    // $0 is never forwarded
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, st);
    issue(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, st);
    chk("r0_stalls", st, 0);
    chk("r0_sel_a", sel_a, 0);
    chk("r0_sel_b", sel_b, 0);
    idle_cycles(4);

    // $7 produced in both MEM and EX: youngest wins
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, st);
    issue(5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, st);
    issue(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, st);
    chk("young_stalls", st, S_EX_ALU);
    chk("young_sel_a", sel_a, C_EX_ALU);
    idle_cycles(4);

    // hold during load-use freezes everything
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, st);
    present(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
    hold = 1'b1;
    @(negedge clk);
    chk("hold_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_sel_a", sel_a, 0);
    hold = 1'b0;
    #1 chk("hold_rel_stall", stall, 1);
    issue(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, st);
    chk("hold_rel_stalls", st, S_EX_LD);
    chk("hold_rel_sel_a", sel_a, C_LOAD);
    idle_cycles(4);

    // flush in the load-use cycle inserts a bubble without stalling
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1, st);
    present(5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", stall, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle_id();
    chk("flush_sel_a", sel_a, 0);
    issue(5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, st);
    chk("flush_after_stalls", st, S_MEM_LD);
    chk("flush_after_sel_a", sel_a, C_LOAD);
    idle_cycles(4);

    // asynchronous reset mid-stream
    issue(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, st);
    issue(5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, st);
    chk("pre_rst_sel_a", sel_a, C_EX_ALU);
    present(5'd11, 1'b1, 5'd11, 1'b1, 1'b1, 5'd12, 1'b0);
    #1 chk("pre_rst_stall", stall, STALL_NOW_EX_ALU);
    rst = 1'b1;
    #1;
    chk("rst_mid_sel_a", sel_a, 0);
    chk("rst_mid_sel_b", sel_b, 0);
    chk("rst_mid_stall", stall, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(5'd11, 1'b1, 5'd11, 1'b1, 1'b1, 5'd12, 1'b0, st);
    chk("post_rst_stalls", st, 0);
    chk("post_rst_sel_a", sel_a, 0);
    chk("post_rst_sel_b", sel_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_fwd_ctrl.md
# operand_fwd_ctrl

Operand-forwarding controller for the pipelined CPU: it drives the 3-bit select codes of the two 8:1 32-bit operand muxes at the EX stage. It tracks destination registers of in-flight instructions in EX, MEM and WB. Every cycle it decides, for the instruction in ID, whether each source operand comes from the register file or a bypass path, or whether the pipe must stall for a load-use hazard. Select codes are registered at the ID/EX boundary, so they are valid throughout the consumer's EX cycle.

## Interface
- `SEL_W`, 3: select-code width, matching the 8-input operand mux.
- `RA_W`, 5: register-address width.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs`, `id_rt` input RA_W: source register addresses.
- `id_rs_used`, `id_rt_used` input 1: the corresponding source is read.
- `id_wreg` input 1: the ID instruction writes a GPR.
- `id_rd` input RA_W: destination register of the ID instruction.
- `id_is_load` input 1: result comes from data memory.
- `hold` input 1: external freeze, e.g. multicycle mul/div busy.
- `flush` input 1: squash the ID instruction, e.g. taken branch.
- `stall` output 1: combinational load-use stall request to the PC/IF/ID registers.
- `sel_a`, `sel_b` output SEL_W: registered operand-mux selects for rs and rt.

## Operation
- Tracker: a 3-entry shift pipe EX→MEM→WB. Each entry is {v, wreg, rd, is_load}.
- Match: entry.v & entry.wreg & entry.rd == src & src != 0 & src_used. Register 0 never matches.
- Priority per source: EX > MEM > WB. The youngest producer wins.
- Code, as seen by the consumer in its EX cycle:
  - 0: register file. Used when no match, or on a WB match, because the regfile writes through.
  - 1: MEM-stage ALU result. Used on an EX match where the producer is not a load.
  - 2: WB-stage ALU result. Used on a MEM match where the producer is not a load.
  - 3: WB-stage load data. Used on a MEM match where the producer is a load.
  - 4–7: reserved, never driven.
- Load-use: an EX match with is_load asserts `stall` = id_valid & !flush & !hold. After one stall cycle the load is in MEM and code 3 applies.
- Per-edge update priority: rst > hold > flush > stall > advance.
  - hold: all state and `sel_*` are frozen.
  - flush: bubble into EX; `sel_*` <= 0; MEM/WB shift.
  - stall: bubble into EX; `sel_*` <= 0; MEM/WB shift; the ID instruction re-evaluates the next cycle.
  - advance: the ID fields load into EX with v = id_valid; `sel_*` <= computed codes.
- An invalid ID instruction (`id_valid` = 0) loads a bubble and `sel_*` <= 0.

## Timing
- Reset: all tracker entries have v = 0; `sel_a` = `sel_b` = 0; `stall` = 0.
- Reset mid-operation clears the pipeline immediately, asynchronously.
- `stall` is combinational from ID inputs and tracker state, with no cycle latency.
- `sel_*` have 1-cycle latency: decided in the consumer's ID cycle, valid for its whole EX cycle.
- Load-use costs exactly 1 bubble. Back-to-back loads feeding each other cost 1 bubble per dependency.
- rs and rt are evaluated independently. A stall on either source stalls the instruction, and neither select is updated.
- `hold` together with `flush` or a stall condition: `hold` wins and nothing changes. `stall` stays low while `hold` is high.

## Configuration
- `OPFWD_BYPASS_EN` defined: forwarding as described above.
- Undefined: no bypass paths. Any EX or MEM match stalls, for loads and non-loads alike. `sel_*` are always 0. WB matches rely on regfile write-through as before.

## Structure
- Shared package `cpu_pkg`:
  - select-code constants `OPSEL_RF`=0, `OPSEL_MEM_ALU`=1, `OPSEL_WB_ALU`=2, `OPSEL_WB_LOAD`=3.
  - `SEL_W`, `RA_W`.
  - the tracker entry typedef.
- One sub-module: `fwd_match`, combinational. Inputs: one source address, its used flag, and the three entries. Outputs: code and load-hazard. It is instantiated twice, for rs and rt.

## Test plan
- After reset, idle 3 cycles → `sel_a` = `sel_b` = 0, `stall` = 0.
- `add $3` then `sub` using rs=$3 → consumer's EX cycle has `sel_a` = 1. With a 1-instruction gap → `sel_a` = 2. With a 2-instruction gap → `sel_a` = 0.
- `lw $5` then `add` using rt=$5 → `stall` = 1 for one cycle, bubble inserted, then `sel_b` = 3. With `OPFWD_BYPASS_EN` undefined → 2 stall cycles, `sel_b` = 0.
- Write $0 then read $0 → no stall, selects 0. Writes to $7 in both EX and MEM, consumer reads $7 → `sel_a` = 1, since the youngest producer wins.
- `hold` asserted during a load-use hazard → `stall` = 0 and state frozen. Release `hold` → normal 1-cycle stall.
- `flush` in the same cycle as a load-use hazard → `stall` = 0, bubble inserted. Assert `rst` mid-stream → selects 0 immediately and all matches cleared.
